multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states using the opcode from the instruction register.
- Drives every datapath enable and mux select, including the 2-bit UCon code consumed directly downstream by ALUControl (00 = add, 01 = subtract, 10 = decode funct).
- Supports variable-latency memory through a ready handshake, traps on illegal opcodes, and counts retired instructions.

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// The master side is the controller: it reads the opcode and memory
// ready and drives every datapath enable and mux select.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             MemReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemToReg;
    logic             IRWrite;
    logic [1:0]       PCSource;
    logic [1:0]       UCon;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegWrite;
    logic             RegDst;
    logic             IllegalOp;
    logic             InstrDone;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg,
               IRWrite, PCSource, UCon, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               IllegalOp, InstrDone, InstrCount
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg,
               IRWrite, PCSource, UCon, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               IllegalOp, InstrDone, InstrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore machine: controls decode from the state register, except IRWrite,
// PCWrite (FETCH) and InstrDone (MEMWR), which also follow MemReady.
// Optional feature: define MC_ADDI_EN to execute addi (opcode 001000);
// without it addi traps like any other unknown opcode.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                Clk,
    input  logic                RstN,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] ucon;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t           state;
    state_t           next_state;
    ctrl_t            ctrl;
    logic             illegal;
    logic [CNT_W-1:0] count;

    // State register; reset aborts any instruction in flight.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) state <= S_RESET;
        else       state <= next_state;
    end

    // Next-state: instruction sequencing from opcode and memory ready.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        next_state = S_TRAP;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  next_state = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      next_state = S_ADDIEX;
`else
                    OP_ADDI:      next_state = S_TRAP;
`endif
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR:  next_state = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = bus.MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:    next_state = S_RTYPEWB;
            S_RTYPEWB: next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX:  next_state = S_ADDIWB;
            S_ADDIWB:  next_state = S_FETCH;
`else
            S_ADDIEX, S_ADDIWB: next_state = S_TRAP;
`endif
            S_TRAP:    next_state = S_TRAP;
            default:   next_state = S_TRAP;
        endcase
    end

    // Output decode: datapath controls per state, zero unless listed.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = bus.MemReady;
                ctrl.pc_write  = bus.MemReady;
            end
            S_DECODE: ctrl.alu_src_b = 2'b11;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.ior_d      = 1'b1;
                ctrl.instr_done = bus.MemReady;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.ucon      = 2'b10;
            end
            S_RTYPEWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.ucon          = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b10;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`else
            S_ADDIEX, S_ADDIWB: ctrl = '0;
`endif
            default: ctrl = '0;
        endcase
    end

    // Sticky trap flag, set on the edge that enters TRAP.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN)                    illegal <= 1'b0;
        else if (next_state == S_TRAP) illegal <= 1'b1;
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN)                count <= '0;
        else if (ctrl.instr_done) count <= count + CNT_W'(1);
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.ior_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemToReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.UCon        = ctrl.ucon;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.IllegalOp   = illegal;
    assign bus.InstrDone   = ctrl.instr_done;
    assign bus.InstrCount  = count;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is modelled
// as its list of datapath phases with the spec's control values per phase;
// memory phases repeat for random MemReady stalls. Counter width is 4 so
// the retired-instruction counter wraps within the run.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum {
        P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
        P_EXEC, P_RTYPEWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB, P_TRAP
    } ph_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] ucon;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    logic Clk = 1'b0;
    logic RstN;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    ctrl_t obs_ctrl;
    assign obs_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                       bus.MemWrite, bus.MemToReg, bus.IRWrite, bus.PCSource,
                       bus.UCon, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite,
                       bus.RegDst, bus.IllegalOp, bus.InstrDone};

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] model_count = '0;
    int               instr_cycles;
    int               done_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected controls for one cycle of a phase, straight from the phase table.
    function automatic ctrl_t exp_ctrl(input ph_t ph, input logic rdy);
        ctrl_t c;
        c = '0;
        case (ph)
            P_FETCH:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            P_DECODE:  c.alu_src_b = 2'b11;
            P_MEMADR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            P_MEMRD:   begin c.mem_read = 1; c.ior_d = 1; end
            P_MEMWB:   begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
            P_MEMWR:   begin c.mem_write = 1; c.ior_d = 1; c.instr_done = rdy; end
            P_EXEC:    begin c.alu_src_a = 1; c.ucon = 2'b10; end
            P_RTYPEWB: begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
            P_BRANCH:  begin c.alu_src_a = 1; c.ucon = 2'b01; c.pc_write_cond = 1;
                             c.pc_source = 2'b01; c.instr_done = 1; end
            P_JUMP:    begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            P_ADDIEX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            P_ADDIWB:  begin c.reg_write = 1; c.instr_done = 1; end
            P_TRAP:    c.illegal_op = 1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_J || op == OP_BEQ || op == OP_ADDI ||
               op == OP_LW || op == OP_SW;
    endfunction

    // One clock cycle in the given phase: drive MemReady, compare, advance.
    task automatic step(input ph_t ph, input logic rdy);
        ctrl_t e;
        @(negedge Clk);
        bus.MemReady = rdy;
        #1;
        e = exp_ctrl(ph, rdy);
        check({ph.name(), " ctrl"}, 32'(obs_ctrl), 32'(e));
        check({ph.name(), " count"}, 32'(bus.InstrCount), 32'(model_count));
        instr_cycles++;
        if (bus.InstrDone === 1'b1 && done_at == 0) done_at = instr_cycles;
        @(posedge Clk);
        if (e.instr_done) model_count = model_count + 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " ctrl"}, 32'(obs_ctrl), 32'h0);
        check({tag, " count"}, 32'(bus.InstrCount), 32'h0);
    endtask

    // Hold reset across a rising edge, release, and check the RESET cycle.
    task automatic hold_and_release();
        @(negedge Clk);
        #1 reset_checks("rst held");
        #1 RstN = 1'b1;
        #1 reset_checks("rst state");
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #1 RstN = 1'b0;
        model_count = '0;
        #1 reset_checks("rst assert");
        hold_and_release();
    endtask

    // Run one instruction: wf stall cycles in FETCH, wm stall cycles in
    // the data-memory phase (lw/sw only). Traps are held 20 cycles, then reset.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        int  base;
        bit  trap;
        int  mem_waits;
        instr_cycles = 0;
        done_at      = 0;
        trap         = 0;
        base         = 0;
        mem_waits    = 0;
        #1 bus.Opcode = op;
        repeat (wf) step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b1);
        step(P_DECODE, rnd_bit());
        case (op)
            OP_LW: begin
                step(P_MEMADR, rnd_bit());
                repeat (wm) step(P_MEMRD, 1'b0);
                step(P_MEMRD, 1'b1);
                step(P_MEMWB, rnd_bit());
                base = 5; mem_waits = wm;
            end
            OP_SW: begin
                step(P_MEMADR, rnd_bit());
                repeat (wm) step(P_MEMWR, 1'b0);
                step(P_MEMWR, 1'b1);
                base = 4; mem_waits = wm;
            end
            OP_RTYPE: begin
                step(P_EXEC, rnd_bit());
                step(P_RTYPEWB, rnd_bit());
                base = 4;
            end
            OP_BEQ: begin step(P_BRANCH, rnd_bit()); base = 3; end
            OP_J:   begin step(P_JUMP, rnd_bit()); base = 3; end
`ifdef MC_ADDI_EN
            OP_ADDI: begin
                step(P_ADDIEX, rnd_bit());
                step(P_ADDIWB, rnd_bit());
                base = 4;
            end
`else
            OP_ADDI: trap = 1;
`endif
            default: trap = 1;
        endcase
        if (trap) begin
            for (int i = 0; i < 20; i++) begin
                bus.Opcode = 6'($urandom);
                step(P_TRAP, rnd_bit());
            end
            do_reset();
        end else begin
            check("latency", 32'(done_at), 32'(base + wf + mem_waits));
        end
    endtask

    logic [5:0] pool [6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};

    initial begin
        logic [CNT_W-1:0] saved;
        logic [5:0]       op;
        bus.MemReady = 1'b0;
        bus.Opcode   = OP_RTYPE;
        RstN         = 1'b1;
        #1 RstN = 1'b0;
        #2 reset_checks("power-on");
        hold_and_release();

        // Directed sequences.
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 2);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(6'b111111, 0, 0);

        // Sixteen jumps bring the 4-bit counter back to where it started.
        @(negedge Clk);
        saved = model_count;
        @(posedge Clk);
        for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0);
        @(negedge Clk);
        #1 check("wrap count", 32'(bus.InstrCount), 32'(saved));
        @(posedge Clk);

        // Randomized instruction mix with random stalls.
        for (int i = 0; i < 80; i++) begin
            run_instr(pool[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Random illegal opcodes.
        for (int i = 0; i < 3; i++) begin
            do op = 6'($urandom); while (is_legal(op));
            run_instr(op, $urandom_range(0, 2), 0);
        end

        // Reset mid-store: MemWrite must drop asynchronously.
        instr_cycles = 0;
        done_at      = 0;
        #1 bus.Opcode = OP_SW;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b1);
        step(P_MEMADR, 1'b1);
        step(P_MEMWR, 1'b0);
        @(negedge Clk);
        bus.MemReady = 1'b0;
        #1 check("memwr held", 32'(obs_ctrl), 32'(exp_ctrl(P_MEMWR, 1'b0)));
        #1 RstN = 1'b0;
        model_count = '0;
        #1 check("abort memwrite", 32'(bus.MemWrite), 32'h0);
        reset_checks("abort");
        hold_and_release();
        run_instr(OP_RTYPE, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
